// File: rtl/mtimer_pkg.sv
// mtimer_pkg
//   Shared definitions for the memory-mapped machine timer:
//   register byte offsets, the CTRL register layout and a byte-lane
//   merge helper used by every writable register.
package mtimer_pkg;

    localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
    localparam logic [4:0] CTRL_OFS        = 5'h10;

    // CTRL register as seen on the bus: [0]=EN, [8+]=DIV, rest read 0.
    // div is sized for the widest legal prescaler; unused upper bits stay 0.
    typedef struct packed {
        logic [23:0] div;
        logic [6:0]  reserved;
        logic        en;
    } mtimer_ctrl_t;

    // Replace the bytes of old_val whose enable is set with bytes of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  ben);
        logic [31:0] res;
        res = old_val;
        for (int unsigned k = 0; k < 4; k++) begin
            if (ben[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler
//   Prescale counter for the machine timer. Counts while enabled and emits
//   a one-cycle tick when the count equals DIV, returning to zero.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   en_i            count enable (frozen when low)
//   div_i           terminal count; tick period is div_i+1 cycles
//   tick_o          combinational tick, high on the cycle mtime advances
module mtimer_prescaler #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == div_i);

    // If DIV is lowered below the current count, the counter keeps going up,
    // wraps through zero and only then meets DIV again.
    always_comb begin
        pcnt_d = pcnt_q;
        if (tick_o) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// mtimer
//   Memory-mapped RISC-V machine timer: free-running 64-bit mtime with a
//   programmable prescaler, 64-bit mtimecmp and a registered level IRQ.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   sel_i           block select from top-level address decode
//   addr_i          byte offset (addr_i[1:0] ignored)
//   wen_i, ben_i    write enable and byte enables
//   wdata_i         write data
//   rdata_o         combinational read data (0 when sel_i=0)
//   timer_irq_o     registered mtime >= mtimecmp
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8,
    parameter logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sel_i,
    input  logic [4:0]  addr_i,
    input  logic        wen_i,
    input  logic [3:0]  ben_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        timer_irq_o
);

    logic [63:0]  mtime_q, mtime_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    mtimer_ctrl_t ctrl_q, ctrl_d;
    logic         irq_q, irq_d;
    logic         tick;
    logic         wr;
    logic [31:0]  ctrl_merged;

    // All-zero byte enables make the access a no-op, including for the
    // write-wins-over-tick rule on mtime.
    assign wr = sel_i && wen_i && (|ben_i);

    mtimer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (ctrl_q.en),
        .div_i   (ctrl_q.div[PRESCALE_W-1:0]),
        .tick_o  (tick)
    );

    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        ctrl_d      = ctrl_q;
        ctrl_merged = merge_bytes(ctrl_q, wdata_i, ben_i);

        if (wr && addr_i[4:2] == MTIME_LO_OFS[4:2]) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata_i, ben_i);
        end else if (wr && addr_i[4:2] == MTIME_HI_OFS[4:2]) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, ben_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr && addr_i[4:2] == MTIMECMP_LO_OFS[4:2]) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wdata_i, ben_i);
        end
        if (wr && addr_i[4:2] == MTIMECMP_HI_OFS[4:2]) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, ben_i);
        end

        // Only EN and the implemented DIV bits are stored.
        if (wr && addr_i[4:2] == CTRL_OFS[4:2]) begin
            ctrl_d                       = '0;
            ctrl_d.en                    = ctrl_merged[0];
            ctrl_d.div[PRESCALE_W-1:0]   = ctrl_merged[8 +: PRESCALE_W];
        end

        irq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= CMP_RST;
            ctrl_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end

    assign timer_irq_o = irq_q;

    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            unique case (addr_i[4:2])
                MTIME_LO_OFS[4:2]:    rdata_o = mtime_q[31:0];
                MTIME_HI_OFS[4:2]:    rdata_o = mtime_q[63:32];
                MTIMECMP_LO_OFS[4:2]: rdata_o = mtimecmp_q[31:0];
                MTIMECMP_HI_OFS[4:2]: rdata_o = mtimecmp_q[63:32];
                CTRL_OFS[4:2]:        rdata_o = ctrl_q;
                default:              rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mtimer.sv
module tb_mtimer;

    logic        clk_i;
    logic        rst_n_i;
    logic        sel_i;
    logic [4:0]  addr_i;
    logic        wen_i;
    logic [3:0]  ben_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        timer_irq_o;

    int n_checks;
    int n_fail;

    mtimer #(
        .PRESCALE_W (8),
        .CMP_RST    (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .sel_i       (sel_i),
        .addr_i      (addr_i),
        .wen_i       (wen_i),
        .ben_i       (ben_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .timer_irq_o (timer_irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reset pulse; returns just after a negedge with reset released.
    task automatic do_reset();
        sel_i   = 1'b0;
        wen_i   = 1'b0;
        ben_i   = 4'h0;
        addr_i  = 5'h0;
        wdata_i = 32'h0;
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // Called just after a negedge: write lands on the next posedge,
    // returns on the following negedge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        sel_i   = 1'b1;
        wen_i   = 1'b1;
        addr_i  = a;
        wdata_i = d;
        ben_i   = b;
        @(posedge clk_i);
        @(negedge clk_i);
        sel_i = 1'b0;
        wen_i = 1'b0;
        ben_i = 4'h0;
    endtask

    // Combinational read within the current low phase.
    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        sel_i  = 1'b1;
        addr_i = a;
        #1;
        d      = rdata_o;
        sel_i  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        wr(5'h10, 32'h0000_0001, 4'hF);
        wr(5'h08, 32'h0000_0000, 4'hF);
        wr(5'h0C, 32'h0000_0000, 4'hF);
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (timer_irq_o !== 1'b1) begin
            $display("FAIL reset_pre_irq: got %b want 1", timer_irq_o);
            n_fail++;
        end
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (timer_irq_o !== 1'b0) begin
            $display("FAIL reset_async_irq: got %b want 0", timer_irq_o);
            n_fail++;
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL reset_mtime_lo: got %h want 0", d); n_fail++; end
        peek(5'h04, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL reset_mtime_hi: got %h want 0", d); n_fail++; end
        @(negedge clk_i);
        peek(5'h08, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin $display("FAIL reset_cmp_lo: got %h want ffffffff", d); n_fail++; end
        peek(5'h0C, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin $display("FAIL reset_cmp_hi: got %h want ffffffff", d); n_fail++; end
        peek(5'h10, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL reset_ctrl: got %h want 0", d); n_fail++; end
        @(negedge clk_i);
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL reset_mtime_frozen: got %h want 0", d); n_fail++; end
        n_checks++;
        if (timer_irq_o !== 1'b0) begin $display("FAIL reset_irq: got %b want 0", timer_irq_o); n_fail++; end
    endtask

    task automatic test_count_irq();
        logic [31:0] d;
        do_reset();
        wr(5'h08, 32'h0000_0005, 4'hF);
        wr(5'h0C, 32'h0000_0000, 4'hF);
        wr(5'h10, 32'h0000_0001, 4'hF);
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'd0) begin $display("FAIL count_start: got %0d want 0", d); n_fail++; end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_i);
            peek(5'h00, d);
            n_checks++;
            if (d !== 32'(k)) begin
                $display("FAIL count_mtime[%0d]: got %0d want %0d", k, d, k);
                n_fail++;
            end
            n_checks++;
            if (timer_irq_o !== (k >= 6)) begin
                $display("FAIL count_irq[%0d]: got %b want %b", k, timer_irq_o, (k >= 6));
                n_fail++;
            end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        do_reset();
        wr(5'h10, 32'h0000_0301, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            peek(5'h00, d);
            n_checks++;
            if (d !== 32'(k / 4)) begin
                $display("FAIL div3_mtime[%0d]: got %0d want %0d", k, d, k / 4);
                n_fail++;
            end
        end
        // Disable lands one edge after the tick: pcnt left at 1.
        wr(5'h10, 32'h0000_0300, 4'hF);
        repeat (10) @(negedge clk_i);
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'd2) begin $display("FAIL div3_frozen: got %0d want 2", d); n_fail++; end
        peek(5'h10, d);
        n_checks++;
        if (d !== 32'h0000_0300) begin $display("FAIL div3_ctrl_read: got %h want 00000300", d); n_fail++; end
        wr(5'h10, 32'h0000_0301, 4'hF);
        @(negedge clk_i);
        @(negedge clk_i);
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'd2) begin $display("FAIL div3_resume_early: got %0d want 2", d); n_fail++; end
        @(negedge clk_i);
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'd3) begin $display("FAIL div3_resume_tick: got %0d want 3", d); n_fail++; end
    endtask

    task automatic test_wrap();
        logic [31:0] lo, hi;
        do_reset();
        wr(5'h00, 32'hFFFF_FFFE, 4'hF);
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h10, 32'h0000_0001, 4'hF);
        @(negedge clk_i);
        peek(5'h04, hi);
        peek(5'h00, lo);
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            $display("FAIL wrap_max: got %h want ffffffffffffffff", {hi, lo}); n_fail++;
        end
        n_checks++;
        if (timer_irq_o !== 1'b0) begin $display("FAIL wrap_irq_before: got %b want 0", timer_irq_o); n_fail++; end
        @(negedge clk_i);
        peek(5'h04, hi);
        peek(5'h00, lo);
        n_checks++;
        if ({hi, lo} !== 64'h0) begin $display("FAIL wrap_zero: got %h want 0", {hi, lo}); n_fail++; end
        n_checks++;
        if (timer_irq_o !== 1'b1) begin $display("FAIL wrap_irq_high: got %b want 1", timer_irq_o); n_fail++; end
        @(negedge clk_i);
        peek(5'h04, hi);
        peek(5'h00, lo);
        n_checks++;
        if ({hi, lo} !== 64'h1) begin $display("FAIL wrap_one: got %h want 1", {hi, lo}); n_fail++; end
        n_checks++;
        if (timer_irq_o !== 1'b0) begin $display("FAIL wrap_irq_low: got %b want 0", timer_irq_o); n_fail++; end
    endtask

    task automatic test_collision();
        logic [31:0] lo, hi;
        do_reset();
        wr(5'h00, 32'h1234_5678, 4'hF);
        wr(5'h04, 32'hAABB_CCDD, 4'hF);
        wr(5'h10, 32'h0000_0301, 4'hF);
        repeat (3) @(negedge clk_i);
        // This write lands on the edge where pcnt==DIV.
        wr(5'h00, 32'h0000_0100, 4'b0011);
        peek(5'h00, lo);
        peek(5'h04, hi);
        n_checks++;
        if (lo !== 32'h1234_0100) begin $display("FAIL coll_lo: got %h want 12340100", lo); n_fail++; end
        n_checks++;
        if (hi !== 32'hAABB_CCDD) begin $display("FAIL coll_hi: got %h want aabbccdd", hi); n_fail++; end
        repeat (3) @(negedge clk_i);
        peek(5'h00, lo);
        n_checks++;
        if (lo !== 32'h1234_0100) begin $display("FAIL coll_pcnt_early: got %h want 12340100", lo); n_fail++; end
        @(negedge clk_i);
        peek(5'h00, lo);
        n_checks++;
        if (lo !== 32'h1234_0101) begin $display("FAIL coll_pcnt_tick: got %h want 12340101", lo); n_fail++; end
    endtask

    task automatic test_reads();
        logic [31:0] d;
        do_reset();
        wr(5'h14, 32'hFFFF_FFFF, 4'hF);
        wr(5'h08, 32'h0000_0000, 4'h0);
        wr(5'h00, 32'h5555_5555, 4'h0);
        wr(5'h0C, 32'h0000_00A5, 4'b0001);
        peek(5'h14, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL rd_unmapped: got %h want 0", d); n_fail++; end
        peek(5'h00, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL rd_ben0_mtime: got %h want 0", d); n_fail++; end
        peek(5'h0A, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin $display("FAIL rd_cmp_lo_misalign: got %h want ffffffff", d); n_fail++; end
        @(negedge clk_i);
        peek(5'h0C, d);
        n_checks++;
        if (d !== 32'hFFFF_FFA5) begin $display("FAIL rd_cmp_hi_byte: got %h want ffffffa5", d); n_fail++; end
        peek(5'h10, d);
        n_checks++;
        if (d !== 32'h0) begin $display("FAIL rd_ctrl_after_14: got %h want 0", d); n_fail++; end
        addr_i = 5'h08;
        #1;
        n_checks++;
        if (rdata_o !== 32'h0) begin $display("FAIL rd_nosel: got %h want 0", rdata_o); n_fail++; end
        @(negedge clk_i);
        wr(5'h10, 32'hFFFF_FFFE, 4'hF);
        peek(5'h10, d);
        n_checks++;
        if (d !== 32'h0000_FF00) begin $display("FAIL rd_ctrl_mask: got %h want 0000ff00", d); n_fail++; end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n_i  = 1'b0;
        sel_i    = 1'b0;
        wen_i    = 1'b0;
        ben_i    = 4'h0;
        addr_i   = 5'h0;
        wdata_i  = 32'h0;
        @(negedge clk_i);
        test_reset();
        test_count_irq();
        test_prescale();
        test_wrap();
        test_collision();
        test_reads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
